// File: rtl/pair_dot_acc.sv
// rtl/pair_dot_acc.sv - two-stage signed dot-product accumulator over N (a,b) pairs
// Optional DOT_SAT_EN: saturating accumulation with a sticky per-vector overflow flag.
module pair_dot_acc #(
    parameter int W     = 32,
    parameter int N     = 8,
    parameter int ACC_W = 72
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    input  logic signed [W-1:0]     a,
    input  logic signed [W-1:0]     b,
    output logic                    in_ready,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [ACC_W-1:0] dot,
    output logic                    overflow
);
    localparam int            CW       = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(N - 1);

    typedef enum logic [1:0] {ST_ACC, ST_DRAIN, ST_HOLD} state_t;
    state_t r_state;
    state_t w_state_next;

    logic [CW-1:0]           r_cnt;
    logic signed [2*W-1:0]   r_p;
    logic                    r_pv;
    logic signed [ACC_W-1:0] r_acc;

    logic                    w_ready;
    logic                    w_accept;
    logic                    w_last;
    logic                    w_release;
    logic signed [2*W-1:0]   w_prod;
    logic signed [ACC_W-1:0] w_p_ext;
    logic signed [ACC_W-1:0] w_sum;
    logic signed [ACC_W-1:0] w_acc_next;

    // Gating with reset keeps in_ready low for the whole time reset is held.
    assign w_ready   = reset & (r_state == ST_ACC);
    assign w_accept  = in_valid & w_ready;
    assign w_last    = w_accept & (r_cnt == CNT_LAST);
    assign w_release = (r_state == ST_HOLD) & out_ready;

    assign w_prod  = (2*W)'(a) * (2*W)'(b);
    assign w_p_ext = ACC_W'(r_p);
    assign w_sum   = r_acc + w_p_ext;

    assign in_ready = w_ready;
    assign dot      = r_acc;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_ACC;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        out_valid    = 1'b0;
        case (r_state)
            ST_ACC: begin
                if (w_last) w_state_next = ST_DRAIN;
            end
            ST_DRAIN: begin
                w_state_next = ST_HOLD;
            end
            ST_HOLD: begin
                out_valid = 1'b1;
                if (out_ready) w_state_next = ST_ACC;
            end
            default: begin
                w_state_next = ST_ACC;
            end
        endcase
    end

`ifdef DOT_SAT_EN
    logic r_ovf;
    logic w_sum_ovf;

    // Signed overflow: both addends share a sign that the sum does not.
    assign w_sum_ovf = (r_acc[ACC_W-1] == w_p_ext[ACC_W-1]) &
                       (w_sum[ACC_W-1] != r_acc[ACC_W-1]);

    always_comb begin
        w_acc_next = w_sum;
        if (w_sum_ovf) begin
            w_acc_next = r_acc[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                        : {1'b0, {(ACC_W-1){1'b1}}};
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ovf <= 1'b0;
        end else if (w_release) begin
            r_ovf <= 1'b0;
        end else if (r_pv && w_sum_ovf) begin
            r_ovf <= 1'b1;
        end
    end

    assign overflow = r_ovf;
`else
    assign w_acc_next = w_sum;
    assign overflow   = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
            r_p   <= '0;
            r_pv  <= 1'b0;
            r_acc <= '0;
        end else begin
            r_pv <= w_accept;
            if (w_accept) begin
                r_p   <= w_prod;
                r_cnt <= w_last ? '0 : r_cnt + 1'b1;
            end
            // No product is in flight during HOLD, so the clear never races an add.
            if (w_release) begin
                r_acc <= '0;
                r_cnt <= '0;
            end else if (r_pv) begin
                r_acc <= w_acc_next;
            end
        end
    end
endmodule

// File: tb/tb_pair_dot_acc.sv
// tb/tb_pair_dot_acc.sv - self-checking bench for pair_dot_acc (W=8, N=4, ACC_W=16)
module tb_pair_dot_acc;
    localparam int W     = 8;
    localparam int N     = 4;
    localparam int ACC_W = 16;
    localparam longint MAXV = (longint'(1) <<< (ACC_W - 1)) - 1;
    localparam longint MINV = -(longint'(1) <<< (ACC_W - 1));

    logic                    clk = 1'b0;
    logic                    reset = 1'b1;
    logic                    in_valid = 1'b0;
    logic                    out_ready = 1'b0;
    logic signed [W-1:0]     a = '0;
    logic signed [W-1:0]     b = '0;
    logic                    in_ready;
    logic                    out_valid;
    logic                    overflow;
    logic signed [ACC_W-1:0] dot;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    pair_dot_acc #(.W(W), .N(N), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .a         (a),
        .b         (b),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dot       (dot),
        .overflow  (overflow)
    );

    typedef struct {
        int    va[N];
        int    vb[N];
        int    exp_dot;
        bit    exp_ovf;
        int    bp;
        int    gap;
        string name;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string nm, input logic signed [63:0] act, input logic signed [63:0] exp);
        n_total++;
        if (act !== exp) $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic void model(input int va[N], input int vb[N], output int d, output bit ov);
        longint s = 0;
        logic signed [ACC_W-1:0] t;
        ov = 1'b0;
        for (int i = 0; i < N; i++) begin
            s += longint'(va[i]) * longint'(vb[i]);
`ifdef DOT_SAT_EN
            if (s > MAXV) begin s = MAXV; ov = 1'b1; end
            else if (s < MINV) begin s = MINV; ov = 1'b1; end
`endif
        end
        t = s[ACC_W-1:0];
        d = t;
    endfunction

    task automatic feed(input int va[N], input int vb[N], input int cnt, input int gap_pct,
                        input string nm, output int k);
        int guard = 0;
        bit acc_now;
        k = 0;
        while (k < cnt && guard < 400) begin
            guard++;
            out_ready = 1'($urandom_range(1));
            if ($urandom_range(99) < gap_pct) begin
                in_valid = 1'b0;
                a = W'($urandom);
                b = W'($urandom);
            end else begin
                in_valid = 1'b1;
                a = W'(va[k]);
                b = W'(vb[k]);
            end
            chk({nm, " in_ready_acc"}, in_ready, 1);
            acc_now = in_valid & in_ready;
            step();
            if (acc_now) k++;
        end
        in_valid = 1'b0;
        out_ready = 1'b0;
    endtask

    task automatic run_vec(input int va[N], input int vb[N], input int exp_d, input bit exp_o,
                           input int bp, input int gap_pct, input string nm);
        int k;
        feed(va, vb, N, gap_pct, nm, k);
        if (k < N) begin
            chk({nm, " accept_timeout"}, k, N);
            return;
        end
        chk({nm, " drain_out_valid"}, out_valid, 0);
        chk({nm, " drain_in_ready"}, in_ready, 0);
        step();
        chk({nm, " hold_out_valid"}, out_valid, 1);
        chk({nm, " dot"}, dot, exp_d);
        chk({nm, " overflow"}, overflow, exp_o);
        for (int j = 0; j < bp; j++) begin
            step();
            chk({nm, " bp_out_valid"}, out_valid, 1);
            chk({nm, " bp_dot"}, dot, exp_d);
            chk({nm, " bp_overflow"}, overflow, exp_o);
            chk({nm, " bp_in_ready"}, in_ready, 0);
        end
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        chk({nm, " post_out_valid"}, out_valid, 0);
        chk({nm, " post_in_ready"}, in_ready, 1);
    endtask

    task automatic check_reset_state(input string nm);
        chk({nm, " in_ready"}, in_ready, 0);
        chk({nm, " out_valid"}, out_valid, 0);
        chk({nm, " dot"}, dot, 0);
        chk({nm, " overflow"}, overflow, 0);
    endtask

    initial begin
        int va[N];
        int vb[N];
        int ones[N];
        int k;
        int ed;
        bit eo;
        logic signed [W-1:0] t8;

        tbl[0].va = '{1, 3, 5, 7};       tbl[0].vb = '{2, 4, 6, 8};
        tbl[0].exp_dot = 100;            tbl[0].exp_ovf = 0;
        tbl[0].bp = 0; tbl[0].gap = 0;   tbl[0].name = "s1_basic";
        tbl[1].va = '{-3, 4, -2, 0};     tbl[1].vb = '{5, -7, -6, 100};
        tbl[1].exp_dot = -31;            tbl[1].exp_ovf = 0;
        tbl[1].bp = 0; tbl[1].gap = 0;   tbl[1].name = "s2_signed";
        tbl[2].va = '{2, 4, 6, -8};      tbl[2].vb = '{3, 5, 7, 9};
        tbl[2].exp_dot = -4;             tbl[2].exp_ovf = 0;
        tbl[2].bp = 5; tbl[2].gap = 0;   tbl[2].name = "s3_backpressure";
        tbl[3].va = '{127, 127, 127, 127}; tbl[3].vb = '{127, 127, 127, 127};
`ifdef DOT_SAT_EN
        tbl[3].exp_dot = 32767;          tbl[3].exp_ovf = 1;
`else
        tbl[3].exp_dot = -1020;          tbl[3].exp_ovf = 0;
`endif
        tbl[3].bp = 1; tbl[3].gap = 0;   tbl[3].name = "s5_pos_limit";
        tbl[4].va = '{-128, -128, 1, 50}; tbl[4].vb = '{-128, 127, -1, 50};
        tbl[4].exp_dot = 2627;           tbl[4].exp_ovf = 0;
        tbl[4].bp = 2; tbl[4].gap = 40;  tbl[4].name = "gaps_ovf_clear";
        tbl[5].va = '{-128, -128, -128, -128}; tbl[5].vb = '{127, 127, 127, 127};
`ifdef DOT_SAT_EN
        tbl[5].exp_dot = -32768;         tbl[5].exp_ovf = 1;
`else
        tbl[5].exp_dot = 512;            tbl[5].exp_ovf = 0;
`endif
        tbl[5].bp = 0; tbl[5].gap = 20;  tbl[5].name = "neg_limit";

        #3 reset = 1'b0;
        #1 check_reset_state("reset_async");
        step();
        step();
        check_reset_state("reset_held");
        reset = 1'b1;
        #1 chk("reset_release in_ready", in_ready, 1);
        step();

        for (int i = 0; i < 6; i++)
            run_vec(tbl[i].va, tbl[i].vb, tbl[i].exp_dot, tbl[i].exp_ovf,
                    tbl[i].bp, tbl[i].gap, tbl[i].name);

        // Reset after two of four accepts discards the partial vector.
        for (int i = 0; i < N; i++) begin ones[i] = 1; va[i] = 9 + i; vb[i] = -7; end
        feed(va, vb, 2, 0, "s4_partial", k);
        reset = 1'b0;
        #2 check_reset_state("s4_reset");
        step();
        reset = 1'b1;
        #1 chk("s4_release in_ready", in_ready, 1);
        for (int j = 0; j < 3; j++) step();
        chk("s4_idle out_valid", out_valid, 0);
        run_vec(ones, ones, 4, 0, 0, 0, "s4_ones");

        // Reset while a result is pending in HOLD.
        feed(va, vb, N, 0, "hold_reset_feed", k);
        step();
        chk("hold_reset pending out_valid", out_valid, 1);
        reset = 1'b0;
        #2 check_reset_state("hold_reset");
        step();
        reset = 1'b1;
        step();
        chk("hold_reset idle out_valid", out_valid, 0);
        run_vec(ones, ones, 4, 0, 1, 30, "hold_reset_ones");

        for (int r = 0; r < 25; r++) begin
            for (int i = 0; i < N; i++) begin
                t8 = W'($urandom);
                va[i] = t8;
                t8 = W'($urandom);
                vb[i] = t8;
            end
            if (r % 5 == 0) for (int i = 0; i < N; i++) begin va[i] = -128; vb[i] = (r % 10 == 0) ? -128 : 127; end
            model(va, vb, ed, eo);
            run_vec(va, vb, ed, eo, $urandom_range(3), $urandom_range(50), "random");
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/pair_dot_acc.md
PAIR_DOT_ACC -- requirements
Module: pair_dot_acc

Interface
REQ-001 Parameter W, default 32: width of each signed two's-complement operand a and b.
REQ-002 Parameter N, default 8: number of (a,b) pairs per dot product, N >= 2.
REQ-003 Parameter ACC_W, default 72: signed accumulator and result width, ACC_W >= 2*W.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 in_valid  in  1  pair on a/b is valid this cycle.
REQ-007 a  in  W  signed operand, fed by the upstream pair-delay pipe a_out.
REQ-008 b  in  W  signed operand, fed by the upstream pair-delay pipe b_out.
REQ-009 in_ready  out  1  block accepts a pair this cycle.
REQ-010 out_valid  out  1  dot result valid.
REQ-011 out_ready  in  1  consumer takes the result.
REQ-012 dot  out  ACC_W  signed sum of N products a*b.
REQ-013 overflow  out  1  sticky flag: clamp occurred in the current vector; valid with out_valid.

Function
REQ-014 Accept occurs at a rising edge where in_valid=1 and in_ready=1; a and b are ignored otherwise.
REQ-015 Stage 1: on accept, product register p <= a*b, full 2*W signed; pv <= 1; otherwise pv <= 0.
REQ-016 Stage 2: on each edge with pv=1, acc <= acc + sign_extend(p) to ACC_W.
REQ-017 Counter cnt runs 0..N-1 and increments on accept; it clears when it reaches N-1 on an accept.
REQ-018 FSM states: ACC, DRAIN, HOLD.
REQ-019 ACC: in_ready=1; on the accept with cnt=N-1, go to DRAIN.
REQ-020 DRAIN: in_ready=0; lasts exactly one cycle while the last product accumulates, then go to HOLD.
REQ-021 HOLD: in_ready=0, out_valid=1, dot=acc; dot and overflow stay stable until handshake.
REQ-022 HOLD exit on edge with out_ready=1: go to ACC; acc <= 0; overflow <= 0; cnt <= 0.
REQ-023 Latency: out_valid rises 2 edges after the edge accepting the Nth pair.
REQ-024 Minimum period is N+2 cycles per vector with in_valid and out_ready held high.
REQ-025 in_ready is 0 throughout HOLD, so no accept coincides with a result handshake.
REQ-026 out_ready is ignored outside HOLD.
REQ-027 Gaps in in_valid during ACC stall the count without affecting acc.

Reset
REQ-028 reset=0 asynchronously forces: state=ACC; cnt=0; acc=0; p=0; pv=0; overflow=0; out_valid=0.
REQ-029 While reset=0, in_ready=0; in_ready=1 from the first cycle after reset deasserts.
REQ-030 Reset in any state, including mid-vector or HOLD, discards the partial or pending result; no out_valid follows until N new pairs are accepted.

Configuration
REQ-031 Macro DOT_SAT_EN selects accumulator overflow handling.
REQ-032 DOT_SAT_EN defined: on signed overflow of acc + p, acc clamps to 2^(ACC_W-1)-1 or -2^(ACC_W-1) and overflow is set.
REQ-033 DOT_SAT_EN defined: accumulation continues from the clamped value.
REQ-034 DOT_SAT_EN undefined: acc wraps modulo 2^ACC_W and overflow is tied to 0.

Verification
REQ-035 Scenario 1, W=8, N=4: pairs (1,2),(3,4),(5,6),(7,8) back-to-back with out_ready=1 -> dot=100, overflow=0, out_valid high 2 cycles after the 4th accept.
REQ-036 Scenario 2, W=8, N=4: pairs (-3,5),(4,-7),(-2,-6),(0,100) -> dot=-31.
REQ-037 Scenario 3, back-pressure: out_ready held 0 for 5 cycles in HOLD -> dot stable and in_ready=0 throughout; in_ready=1 the cycle after handshake.
REQ-038 Scenario 4, reset: reset pulsed low after 2 of 4 accepts -> outputs per REQ-028; next 4 pairs of (1,1) -> dot=4.
REQ-039 Scenario 5, W=8, N=4, ACC_W=16: four pairs of (127,127) -> DOT_SAT_EN defined gives dot=32767, overflow=1; undefined gives dot=-1020, overflow=0.
